// File: rtl/uart_pkg.sv
// Shared constants for the UART core: Rx state encoding, synchronizer depth and frame length.
package uart_pkg;

   typedef logic [3:0] rx_state_t;

   localparam rx_state_t IDLE       = 4'd0;
   localparam rx_state_t START_BIT  = 4'd1;
   localparam rx_state_t DATA_BIT_0 = 4'd2;
   localparam rx_state_t DATA_BIT_1 = 4'd3;
   localparam rx_state_t DATA_BIT_2 = 4'd4;
   localparam rx_state_t DATA_BIT_3 = 4'd5;
   localparam rx_state_t DATA_BIT_4 = 4'd6;
   localparam rx_state_t DATA_BIT_5 = 4'd7;
   localparam rx_state_t DATA_BIT_6 = 4'd8;
   localparam rx_state_t DATA_BIT_7 = 4'd9;
   localparam rx_state_t PARITY_BIT = 4'd10;
   localparam rx_state_t STOP_BIT   = 4'd11;

   localparam int SYNC_DEPTH = 3;

   // Frame length: start + data + optional parity + stop.
   function automatic int num_bits(input int data_width, input int parity_en);
      return data_width + parity_en + 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial input; presets to the idle (high) level.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic [SYNC_DEPTH-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_DEPTH-2:0], d};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '1;
      else        sync_q <= sync_d;
   end

   assign q = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: baud generator, PISO transmitter and oversampling receiver FSM.
// Define UART_DEBUG_PORTS_EN to expose state, baud_clk and shift_reg for observation.
module uart_core
   import uart_pkg::*;
#(
   parameter int  INPUT_DATA_WIDTH = 8,
   parameter int  PARITY_ENABLED   = 1,
   parameter int  PARITY_TYPE      = 0,
   parameter int  CLOCKS_PER_BIT   = 8,
   localparam int NUM_BITS         = num_bits(INPUT_DATA_WIDTH, PARITY_ENABLED)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [INPUT_DATA_WIDTH-1:0] i_data,
   output logic                        o_busy,
   output logic                        serial_out,
   input  logic                        serial_in,
   output logic [INPUT_DATA_WIDTH-1:0] received_data,
   output logic                        data_is_valid,
   output logic                        rx_error
`ifdef UART_DEBUG_PORTS_EN
   ,
   output logic [3:0]                  state,
   output logic                        baud_clk,
   output logic [NUM_BITS-1:0]         shift_reg
`endif
);

   localparam int               CNT_W      = $clog2(CLOCKS_PER_BIT);
   localparam int               TXC_W      = $clog2(NUM_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLOCKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [TXC_W-1:0] TXC_LAST   = TXC_W'(NUM_BITS);
   localparam rx_state_t        LAST_DATA  = rx_state_t'(DATA_BIT_0 + INPUT_DATA_WIDTH - 1);
   localparam rx_state_t        AFTER_DATA = (PARITY_ENABLED != 0) ? PARITY_BIT : STOP_BIT;
   localparam logic             PAR_ODD    = (PARITY_TYPE != 0);

   logic [CNT_W-1:0]            baud_cnt_q, baud_cnt_d;
   logic                        baud_tick;
   logic [NUM_BITS-1:0]         shift_q, shift_d, tx_frame;
   logic [TXC_W-1:0]            tx_cnt_q, tx_cnt_d;
   logic                        busy_q, busy_d, tx_line_q, tx_line_d, tx_parity;

   logic                        rx_in, rx_prev_q, rx_prev_d, rx_par_q, rx_par_d, parity_ok;
   rx_state_t                   state_q, state_d;
   logic [CNT_W-1:0]            rx_cnt_q, rx_cnt_d;
   logic [INPUT_DATA_WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
   logic                        valid_q, valid_d, err_q, err_d;

   uart_rx_sync u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (serial_in),
      .q     (rx_in)
   );

   assign baud_tick = (baud_cnt_q == CNT_LAST);
   assign tx_parity = (^i_data) ^ PAR_ODD;
   assign tx_frame  = (PARITY_ENABLED != 0) ? NUM_BITS'({1'b1, tx_parity, i_data, 1'b0})
                                            : NUM_BITS'({1'b1, i_data, 1'b0});
   assign parity_ok = (PARITY_ENABLED == 0) || (rx_par_q == ((^hold_q) ^ PAR_ODD));

   // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latches).
   always_comb begin
      baud_cnt_d = baud_tick ? '0 : baud_cnt_q + 1'b1;
      shift_d    = shift_q;
      tx_cnt_d   = tx_cnt_q;
      busy_d     = busy_q;
      tx_line_d  = tx_line_q;
      if (!busy_q) begin
         if (enable) begin
            shift_d  = tx_frame;
            busy_d   = 1'b1;
            tx_cnt_d = '0;
         end
      end else if (baud_tick) begin
         // First tick only presents the start bit; later ticks shift, the tick after the stop bit ends the frame.
         if (tx_cnt_q == '0) begin
            tx_line_d = shift_q[0];
         end else if (tx_cnt_q < TXC_LAST) begin
            shift_d   = {1'b1, shift_q[NUM_BITS-1:1]};
            tx_line_d = shift_q[1];
         end else begin
            busy_d    = 1'b0;
            tx_line_d = 1'b1;
         end
         tx_cnt_d = (tx_cnt_q == TXC_LAST) ? '0 : tx_cnt_q + 1'b1;
      end
   end

   always_comb begin
      rx_prev_d = rx_in;
      state_d   = state_q;
      rx_cnt_d  = rx_cnt_q + 1'b1;
      hold_d    = hold_q;
      rx_par_d  = rx_par_q;
      rx_data_d = rx_data_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_in) state_d = START_BIT;
         end
         START_BIT: if (rx_cnt_q == CNT_MID) begin
            rx_cnt_d = '0;
            state_d  = rx_in ? IDLE : DATA_BIT_0;
         end
         PARITY_BIT: if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d = '0;
            rx_par_d = rx_in;
            state_d  = STOP_BIT;
         end
         STOP_BIT: if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d = '0;
            state_d  = IDLE;
            if (rx_in && parity_ok) begin
               rx_data_d = hold_q;
               valid_d   = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         default: begin
            if (state_q > LAST_DATA) begin
               state_d = IDLE;
            end else if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d = '0;
               hold_d   = {rx_in, hold_q[INPUT_DATA_WIDTH-1:1]};
               state_d  = (state_q == LAST_DATA) ? AFTER_DATA : state_q + 1'b1;
            end
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
   // NOTE: the data registers are reset too, so received_data reads 0 before the first frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baud_cnt_q <= '0;
         shift_q    <= '1;
         tx_cnt_q   <= '0;
         busy_q     <= 1'b0;
         tx_line_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         state_q    <= IDLE;
         rx_cnt_q   <= '0;
         hold_q     <= '0;
         rx_par_q   <= 1'b0;
         rx_data_q  <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         baud_cnt_q <= baud_cnt_d;
         shift_q    <= shift_d;
         tx_cnt_q   <= tx_cnt_d;
         busy_q     <= busy_d;
         tx_line_q  <= tx_line_d;
         rx_prev_q  <= rx_prev_d;
         state_q    <= state_d;
         rx_cnt_q   <= rx_cnt_d;
         hold_q     <= hold_d;
         rx_par_q   <= rx_par_d;
         rx_data_q  <= rx_data_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign o_busy        = busy_q;
   assign serial_out    = tx_line_q;
   assign received_data = rx_data_q;
   assign data_is_valid = valid_q;
   assign rx_error      = err_q;

`ifdef UART_DEBUG_PORTS_EN
   assign state     = state_q;
   assign baud_clk  = baud_tick;
   assign shift_reg = shift_q;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: loopback traffic, busy gating, external error frames, reset abort.
module tb_uart_core;
   import uart_pkg::*;

   localparam int W   = 8;
   localparam int CPB = 8;
   localparam int NB  = 11;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] i_data = '0;
   logic         o_busy, serial_out, serial_in, data_is_valid, rx_error;
   logic [W-1:0] received_data;
   logic         loop_en = 1'b1;
   logic         ext_line = 1'b1;
`ifdef UART_DEBUG_PORTS_EN
   logic [3:0]    dbg_state;
   logic          dbg_baud;
   logic [NB-1:0] dbg_shift;
`endif

   int           checks = 0;
   int           errors = 0;
   int           valid_cnt = 0;
   int           err_cnt = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v;

   always #5 clk = ~clk;
   assign serial_in = loop_en ? serial_out : ext_line;

   uart_core dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .i_data        (i_data),
      .o_busy        (o_busy),
      .serial_out    (serial_out),
      .serial_in     (serial_in),
      .received_data (received_data),
      .data_is_valid (data_is_valid),
      .rx_error      (rx_error)
`ifdef UART_DEBUG_PORTS_EN
      ,
      .state         (dbg_state),
      .baud_clk      (dbg_baud),
      .shift_reg     (dbg_shift)
`endif
   );

   // Scoreboard: every valid pulse pops the oldest expected word.
   always @(negedge clk) begin
      if (reset) begin
         if (data_is_valid && rx_error) begin
            checks++; errors++;
            $display("FAIL valid_error_overlap: both pulses high at %0t", $time);
         end
         if (data_is_valid) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: got %h, required no frame", received_data);
            end else begin
               exp_v = exp_q.pop_front();
               if (received_data !== exp_v) begin
                  errors++;
                  $display("FAIL rx_data: got %h, required %h", received_data, exp_v);
               end
            end
         end
         if (rx_error) err_cnt++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [W-1:0] d, input bit push);
      int n = 0;
      @(negedge clk);
      while (o_busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
      if (o_busy !== 1'b0) begin
         checks++; errors++;
         $display("FAIL busy_timeout: o_busy=%b, required 0", o_busy);
      end
      enable = 1'b1;
      i_data = d;
      if (push) exp_q.push_back(d);
      @(negedge clk);
      enable = 1'b0;
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL accept: o_busy=%b, required 1", o_busy);
      end
   endtask

   task automatic wait_valid(input int target, input int budget);
      int n = 0;
      while (valid_cnt < target && n < budget) begin @(negedge clk); n++; end
      if (valid_cnt < target) begin
         checks++; errors++;
         $display("FAIL rx_timeout: valid count %0d, required %0d", valid_cnt, target);
      end
   endtask

   task automatic wait_start(output bit found);
      int n = 0;
      while (serial_out !== 1'b0 && n < 40) begin @(negedge clk); n++; end
      found = (serial_out === 1'b0);
      if (!found) begin
         checks++; errors++;
         $display("FAIL start_timeout: serial_out=%b, required 0", serial_out);
      end
   endtask

   task automatic drive_ext(input logic [W-1:0] d, input logic par, input logic stop);
      logic [NB-1:0] bits;
      bits = {stop, par, d, 1'b0};
      for (int b = 0; b < NB; b++) begin
         ext_line = bits[b];
         repeat (CPB) @(negedge clk);
      end
      ext_line = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (serial_out !== 1'b1)    begin errors++; $display("FAIL reset_serial_out: got %b, required 1", serial_out); end
      checks++; if (o_busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
      checks++; if (data_is_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", data_is_valid); end
      checks++; if (rx_error !== 1'b0)      begin errors++; $display("FAIL reset_rx_error: got %b, required 0", rx_error); end
      checks++; if (received_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h, required 00", received_data); end
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_loopback_a5();
      logic [W-1:0]  d;
      logic [NB-1:0] frame;
      logic [7:0]    samples;
      logic          busy_last;
      bit            found;
      int            v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      d = 8'hA5;
      frame = {1'b1, ^d, d, 1'b0};
      send_byte(d, 1'b1);
      wait_start(found);
      if (found) begin
         busy_last = 1'b0;
         for (int b = 0; b < NB; b++) begin
            for (int s = 0; s < CPB; s++) begin
               samples[s] = serial_out;
               busy_last = o_busy;
               @(negedge clk);
            end
            checks++;
            if (samples !== {8{frame[b]}}) begin
               errors++;
               $display("FAIL tx_bit%0d: samples %b, required %b", b, samples, {8{frame[b]}});
            end
         end
         checks++; if (busy_last !== 1'b1) begin errors++; $display("FAIL busy_during_stop: got %b, required 1", busy_last); end
         checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL busy_after_stop: got %b, required 0", o_busy); end
         checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL idle_line: got %b, required 1", serial_out); end
      end
      wait_valid(v0 + 1, 100);
      repeat (20) @(negedge clk);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL a5_valid_count: got %0d, required 1", valid_cnt - v0); end
      checks++; if (err_cnt != e0)       begin errors++; $display("FAIL a5_rx_error: got %0d, required 0", err_cnt - e0); end
      checks++; if (received_data !== 8'hA5) begin errors++; $display("FAIL a5_rx_data: got %h, required a5", received_data); end
   endtask

   task automatic test_busy_reject();
      int v0;
      v0 = valid_cnt;
      send_byte(8'h3C, 1'b1);
      repeat (10) @(negedge clk);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_mid_frame: got %b, required 1", o_busy); end
      enable = 1'b1;
      i_data = 8'hFF;
      @(negedge clk);
      enable = 1'b0;
      wait_valid(v0 + 1, 200);
      repeat (150) @(negedge clk);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL reject_valid_count: got %0d, required 1", valid_cnt - v0); end
      checks++; if (o_busy !== 1'b0)     begin errors++; $display("FAIL reject_busy: got %b, required 0", o_busy); end
      checks++; if (received_data !== 8'h3C) begin errors++; $display("FAIL reject_rx_data: got %h, required 3c", received_data); end
   endtask

   task automatic test_back_to_back();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      wait_valid(v0 + 2, 400);
      repeat (30) @(negedge clk);
      checks++; if (valid_cnt - v0 != 2) begin errors++; $display("FAIL b2b_valid_count: got %0d, required 2", valid_cnt - v0); end
      checks++; if (err_cnt != e0)       begin errors++; $display("FAIL b2b_rx_error: got %0d, required 0", err_cnt - e0); end
      checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
   endtask

   task automatic test_parity_error();
      int v0, e0;
      loop_en = 1'b0;
      ext_line = 1'b1;
      repeat (10) @(negedge clk);
      v0 = valid_cnt; e0 = err_cnt;
      drive_ext(8'h01, 1'b0, 1'b1);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL parity_error_count: got %0d, required 1", err_cnt - e0); end
      checks++; if (valid_cnt != v0)   begin errors++; $display("FAIL parity_valid: got %0d, required 0", valid_cnt - v0); end
      checks++; if (received_data !== 8'hFF) begin errors++; $display("FAIL parity_rx_data: got %h, required ff", received_data); end
      exp_q.push_back(8'h5A);
      drive_ext(8'h5A, 1'b0, 1'b1);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL ext_good_valid: got %0d, required 1", valid_cnt - v0); end
      checks++; if (err_cnt - e0 != 1)   begin errors++; $display("FAIL ext_good_error: got %0d, required 1", err_cnt - e0); end
      drive_ext(8'h33, 1'b0, 1'b0);
      checks++; if (err_cnt - e0 != 2)   begin errors++; $display("FAIL stop_error_count: got %0d, required 2", err_cnt - e0); end
      checks++; if (received_data !== 8'h5A) begin errors++; $display("FAIL stop_rx_data: got %h, required 5a", received_data); end
      loop_en = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      bit found;
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_byte(8'h96, 1'b0);
      wait_start(found);
      repeat (35) @(negedge clk);
      checks++; if (dut.state_q !== DATA_BIT_3) begin errors++; $display("FAIL pre_abort_state: got %0d, required %0d", dut.state_q, DATA_BIT_3); end
      reset = 1'b0;
      #1;
      checks++; if (serial_out !== 1'b1)  begin errors++; $display("FAIL abort_serial_out: got %b, required 1", serial_out); end
      checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b, required 0", o_busy); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL abort_state: got %0d, required 0", dut.state_q); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (250) @(negedge clk);
      checks++; if (valid_cnt != v0)      begin errors++; $display("FAIL abort_spurious_valid: got %0d, required 0", valid_cnt - v0); end
      checks++; if (err_cnt != e0)        begin errors++; $display("FAIL abort_spurious_error: got %0d, required 0", err_cnt - e0); end
      checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL abort_busy_after: got %b, required 0", o_busy); end
      send_byte(8'hC3, 1'b1);
      wait_valid(v0 + 1, 200);
      repeat (20) @(negedge clk);
      checks++; if (received_data !== 8'hC3) begin errors++; $display("FAIL recover_rx_data: got %h, required c3", received_data); end
   endtask

   initial begin
      test_reset();
      test_loopback_a5();
      test_busy_reject();
      test_back_to_back();
      test_parity_error();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
